// File: rtl/pz_sum_tree.sv
// pz_sum_tree: combines CHANNELS signed pole/zero terms into one value per
// pixel. Zeros add and poles subtract. Each term is scaled by a per-channel
// multiplicity. A channel that is disabled, or set in both masks, adds nothing.
// Configuration is double-buffered: cfg_update captures it into staging, and
// it becomes active only on an accepted start-of-frame pixel.
//
// Pipeline: W (weighting) -> T1..Tk (pairwise adder tree) -> F (output format).
// Latency is k+2 ready-high cycles, where k = clog2(CHANNELS).
//
// Ports:
//   clk, reset           sole clock; synchronous active-high reset
//   ready                clock-enable; 0 freezes pipeline, sideband, active cfg
//   in_valid/sof/eol     pixel sideband, delayed alongside the data
//   in_data              CHANNELS signed terms, channel i at [i*DATA_W +: DATA_W]
//   cfg_zero/pole_mask   bit i marks channel i as zero / pole
//   cfg_order            multiplicity of channel i at [i*ORDER_W +: ORDER_W]
//   cfg_update           single-cycle pulse: capture cfg_* into staging
//   out_valid/sof/eol    delayed sideband
//   out_data             sum, wrapped (SATURATE=0) or clamped (SATURATE=1)
//   out_raw              full-precision signed sum
//   cfg_pending          staging holds a configuration not yet applied
//   cfg_error            active configuration has a channel in both masks
module pz_sum_tree #(
    parameter int CHANNELS = 8,
    parameter int DATA_W   = 16,
    parameter int ORDER_W  = 2,
    parameter int SATURATE = 0,
    localparam int ACC_W   = DATA_W + ORDER_W + $clog2(CHANNELS) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ready,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic                          in_eol,
    input  logic [CHANNELS*DATA_W-1:0]    in_data,
    input  logic [CHANNELS-1:0]           cfg_zero_mask,
    input  logic [CHANNELS-1:0]           cfg_pole_mask,
    input  logic [CHANNELS*ORDER_W-1:0]   cfg_order,
    input  logic                          cfg_update,
    output logic                          out_valid,
    output logic                          out_sof,
    output logic                          out_eol,
    output logic [DATA_W-1:0]             out_data,
    output logic signed [ACC_W-1:0]       out_raw,
    output logic                          cfg_pending,
    output logic                          cfg_error
);

    localparam int K = $clog2(CHANNELS);   // adder tree depth
    localparam int P = 1 << K;             // tree width padded to a power of two
    localparam int L = K + 2;              // total pipeline latency

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    // ------------------------------------------------------------------
    // Configuration: staging and active banks
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0]         stg_zero, stg_pole, act_zero, act_pole;
    logic [CHANNELS*ORDER_W-1:0] stg_order, act_order;
    logic [CHANNELS-1:0]         eff_zero, eff_pole;
    logic [CHANNELS*ORDER_W-1:0] eff_order;
    logic                        apply;

    assign apply = ready & in_valid & in_sof & cfg_pending;

    // The SOF pixel that triggers the apply already uses the staged values.
    assign eff_zero  = apply ? stg_zero  : act_zero;
    assign eff_pole  = apply ? stg_pole  : act_pole;
    assign eff_order = apply ? stg_order : act_order;

    // NOTE: state registers use non-blocking assignment so that every
    // register samples values from before the edge. This is what lets the
    // apply copy the old staging while cfg_update overwrites it on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_zero    <= '0;
            stg_pole    <= '0;
            stg_order   <= '0;
            act_zero    <= '0;
            act_pole    <= '0;
            act_order   <= '0;
            cfg_pending <= 1'b0;
            cfg_error   <= 1'b0;
        end else begin
            // Staging capture ignores ready.
            if (cfg_update) begin
                stg_zero  <= cfg_zero_mask;
                stg_pole  <= cfg_pole_mask;
                stg_order <= cfg_order;
            end
            if (apply) begin
                act_zero  <= stg_zero;
                act_pole  <= stg_pole;
                act_order <= stg_order;
                cfg_error <= |(stg_zero & stg_pole);
            end
            if (cfg_update)
                cfg_pending <= 1'b1;
            else if (apply)
                cfg_pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage W: signed term = +/- (order * x), using shift-add only
    // ------------------------------------------------------------------
    function automatic logic signed [ACC_W-1:0] weigh(
        input logic signed [DATA_W-1:0]  x,
        input logic        [ORDER_W-1:0] ord,
        input logic                      is_zero,
        input logic                      is_pole
    );
        logic signed [ACC_W-1:0] xe;
        logic signed [ACC_W-1:0] mag;
        xe  = {{(ACC_W - DATA_W){x[DATA_W-1]}}, x};
        mag = '0;
        for (int b = 0; b < ORDER_W; b++) begin
            if (ord[b])
                mag = mag + (xe <<< b);
        end
        // A channel set in both masks is treated as disabled.
        if (is_zero && !is_pole)
            return mag;
        else if (is_pole && !is_zero)
            return -mag;
        else
            return '0;
    endfunction

    logic signed [ACC_W-1:0] term [P];

    // NOTE: every combinational output gets a default before any
    // conditional assignment. Otherwise synthesis infers a latch to hold
    // the value. The padding slots above CHANNELS rely on this default of 0.
    always_comb begin
        for (int i = 0; i < P; i++)
            term[i] = '0;
        for (int i = 0; i < CHANNELS; i++)
            term[i] = weigh(in_data[i*DATA_W +: DATA_W],
                            eff_order[i*ORDER_W +: ORDER_W],
                            eff_zero[i], eff_pole[i]);
    end

    // ------------------------------------------------------------------
    // Level 0 holds the W registers. Levels 1..K form the adder tree. An odd
    // leftover operand meets one of the zero padding slots.
    // ------------------------------------------------------------------
    for (genvar j = 0; j <= K; j++) begin : lvl_g
        localparam int N = P >> j;
        logic signed [ACC_W-1:0] node [N];

        if (j == 0) begin : w_g
            // NOTE: these register arrays are reset explicitly, unlike a
            // RAM. A mid-frame reset must flush every in-flight sum to 0.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < N; i++)
                        node[i] <= '0;
                end else if (ready) begin
                    for (int i = 0; i < N; i++)
                        node[i] <= term[i];
                end
            end
        end else begin : add_g
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < N; i++)
                        node[i] <= '0;
                end else if (ready) begin
                    for (int i = 0; i < N; i++)
                        node[i] <= lvl_g[j-1].node[2*i] + lvl_g[j-1].node[2*i+1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage F: wrap or clamp into DATA_W
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] tree_sum;
    logic [DATA_W-1:0]       fmt_data;

    assign tree_sum = lvl_g[K].node[0];

    always_comb begin
        fmt_data = tree_sum[DATA_W-1:0];
        if (SATURATE != 0) begin
            if (tree_sum > SAT_MAX)
                fmt_data = {1'b0, {(DATA_W - 1){1'b1}}};
            else if (tree_sum < SAT_MIN)
                fmt_data = {1'b1, {(DATA_W - 1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_raw  <= '0;
            out_data <= '0;
        end else if (ready) begin
            out_raw  <= tree_sum;
            out_data <= fmt_data;
        end
    end

    // ------------------------------------------------------------------
    // Sideband chain of length L. It runs in step with the data stages.
    // ------------------------------------------------------------------
    logic [L-1:0] vld_sr, sof_sr, eol_sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_sr <= '0;
            sof_sr <= '0;
            eol_sr <= '0;
        end else if (ready) begin
            vld_sr <= {vld_sr[L-2:0], in_valid};
            sof_sr <= {sof_sr[L-2:0], in_sof};
            eol_sr <= {eol_sr[L-2:0], in_eol};
        end
    end

    assign out_valid = vld_sr[L-1];
    assign out_sof   = sof_sr[L-1];
    assign out_eol   = eol_sr[L-1];

endmodule

// File: tb/tb_pz_sum_tree.sv
// Testbench for pz_sum_tree. It runs two instances on shared stimulus, one
// wrapping (SATURATE=0) and one clamping (SATURATE=1). A bench-side model of
// the staging and active configuration computes each pixel's expected sum.
// The sum is queued with its due cycle and compared cycle-exactly at the output.
module tb_pz_sum_tree;

    localparam int CH = 8;
    localparam int DW = 16;
    localparam int OW = 2;
    localparam int AW = DW + OW + 3 + 1;
    localparam int LAT = 5;

    logic clk = 1'b0;
    logic reset, ready, in_valid, in_sof, in_eol, cfg_update;
    logic [CH*DW-1:0] in_data;
    logic [CH-1:0]    cfg_zero_mask, cfg_pole_mask;
    logic [CH*OW-1:0] cfg_order;

    logic          w_valid, w_sof, w_eol, w_pend, w_err;
    logic [DW-1:0] w_data;
    logic [AW-1:0] w_raw;
    logic          s_valid, s_sof, s_eol, s_pend, s_err;
    logic [DW-1:0] s_data;
    logic [AW-1:0] s_raw;

    pz_sum_tree #(.CHANNELS(CH), .DATA_W(DW), .ORDER_W(OW), .SATURATE(0)) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol), .in_data(in_data),
        .cfg_zero_mask(cfg_zero_mask), .cfg_pole_mask(cfg_pole_mask),
        .cfg_order(cfg_order), .cfg_update(cfg_update),
        .out_valid(w_valid), .out_sof(w_sof), .out_eol(w_eol),
        .out_data(w_data), .out_raw(w_raw),
        .cfg_pending(w_pend), .cfg_error(w_err)
    );

    pz_sum_tree #(.CHANNELS(CH), .DATA_W(DW), .ORDER_W(OW), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .ready(ready),
        .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol), .in_data(in_data),
        .cfg_zero_mask(cfg_zero_mask), .cfg_pole_mask(cfg_pole_mask),
        .cfg_order(cfg_order), .cfg_update(cfg_update),
        .out_valid(s_valid), .out_sof(s_sof), .out_eol(s_eol),
        .out_data(s_data), .out_raw(s_raw),
        .cfg_pending(s_pend), .cfg_error(s_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sof;
        logic          eol;
        logic [DW-1:0] dw;
        logic [DW-1:0] ds;
        logic [AW-1:0] raw;
        int            due;
    } exp_t;

    exp_t sb [$];

    // Reference configuration state
    logic [CH-1:0]    m_sz, m_sp, m_az, m_ap;
    logic [CH*OW-1:0] m_so, m_ao;
    logic             m_pend, m_err;

    // Expected contents of the output registers after the last ready edge
    logic          ev_valid, ev_sof, ev_eol;
    logic [DW-1:0] ev_dw, ev_ds;
    logic [AW-1:0] ev_raw;

    int    rcyc = 0;
    int    pass_cnt = 0;
    int    total = 0;
    string cur_tag = "init";

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_px(input logic [CH*DW-1:0] d,
                                      input logic [CH-1:0] z, input logic [CH-1:0] p,
                                      input logic [CH*OW-1:0] o,
                                      input logic s, input logic e);
        exp_t   r;
        longint sum;
        longint x;
        int     m;
        sum = 0;
        for (int i = 0; i < CH; i++) begin
            x = longint'($signed(d[i*DW +: DW]));
            m = int'(o[i*OW +: OW]);
            if (z[i] && !p[i])
                sum += m * x;
            else if (p[i] && !z[i])
                sum -= m * x;
        end
        r.sof = s;
        r.eol = e;
        r.raw = sum[AW-1:0];
        r.dw  = sum[DW-1:0];
        if (sum > 32767)
            r.ds = 16'h7FFF;
        else if (sum < -32768)
            r.ds = 16'h8000;
        else
            r.ds = sum[DW-1:0];
        r.due = 0;
        return r;
    endfunction

    task automatic check_state();
        chk({cur_tag, ".valid"},   w_valid, ev_valid);
        chk({cur_tag, ".s_valid"}, s_valid, ev_valid);
        if (ev_valid) begin
            chk({cur_tag, ".sof"},   w_sof,  ev_sof);
            chk({cur_tag, ".eol"},   w_eol,  ev_eol);
            chk({cur_tag, ".s_sof"}, s_sof,  ev_sof);
            chk({cur_tag, ".s_eol"}, s_eol,  ev_eol);
            chk({cur_tag, ".data"},  w_data, ev_dw);
            chk({cur_tag, ".sdata"}, s_data, ev_ds);
            chk({cur_tag, ".raw"},   w_raw,  ev_raw);
            chk({cur_tag, ".sraw"},  s_raw,  ev_raw);
        end
        chk({cur_tag, ".pending"},   w_pend, m_pend);
        chk({cur_tag, ".s_pending"}, s_pend, m_pend);
        chk({cur_tag, ".error"},     w_err,  m_err);
        chk({cur_tag, ".s_error"},   s_err,  m_err);
    endtask

    // One clock: update the model from the current inputs, take the edge,
    // sample #1 later, compare, and then drop the cfg_update pulse.
    task automatic tick();
        logic             apply, rdy, rst;
        logic [CH-1:0]    ez, ep;
        logic [CH*OW-1:0] eo;
        exp_t             e;
        rst = reset;
        rdy = ready;
        if (!rst) begin
            apply = ready && in_valid && in_sof && m_pend;
            ez = apply ? m_sz : m_az;
            ep = apply ? m_sp : m_ap;
            eo = apply ? m_so : m_ao;
            if (ready && in_valid) begin
                e = model_px(in_data, ez, ep, eo, in_sof, in_eol);
                e.due = rcyc + LAT;
                sb.push_back(e);
            end
            if (apply) begin
                m_az  = m_sz;
                m_ap  = m_sp;
                m_ao  = m_so;
                m_err = |(m_sz & m_sp);
            end
            if (cfg_update) begin
                m_sz = cfg_zero_mask;
                m_sp = cfg_pole_mask;
                m_so = cfg_order;
            end
            if (cfg_update)
                m_pend = 1'b1;
            else if (apply)
                m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            m_sz = '0; m_sp = '0; m_so = '0;
            m_az = '0; m_ap = '0; m_ao = '0;
            m_pend = 1'b0; m_err = 1'b0;
            ev_valid = 1'b0; ev_sof = 1'b0; ev_eol = 1'b0;
            ev_dw = '0; ev_ds = '0; ev_raw = '0;
            chk({cur_tag, ".rst_data"},  w_data, 0);
            chk({cur_tag, ".rst_sdata"}, s_data, 0);
            chk({cur_tag, ".rst_raw"},   w_raw,  0);
            chk({cur_tag, ".rst_sof"},   w_sof,  0);
            chk({cur_tag, ".rst_eol"},   w_eol,  0);
        end else if (rdy) begin
            rcyc++;
            if (sb.size() > 0 && sb[0].due == rcyc) begin
                e = sb.pop_front();
                ev_valid = 1'b1;
                ev_sof = e.sof; ev_eol = e.eol;
                ev_dw = e.dw; ev_ds = e.ds; ev_raw = e.raw;
            end else begin
                ev_valid = 1'b0;
            end
        end
        check_state();
        cfg_update = 1'b0;
    endtask

    task automatic load_cfg(input logic [CH-1:0] z, input logic [CH-1:0] p,
                            input logic [CH*OW-1:0] o);
        cfg_zero_mask = z;
        cfg_pole_mask = p;
        cfg_order     = o;
        cfg_update    = 1'b1;
    endtask

    task automatic rand_data(output logic [CH*DW-1:0] d);
        for (int i = 0; i < CH; i++)
            d[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic send(input logic v, input logic s, input logic e,
                        input logic [CH*DW-1:0] d);
        in_valid = v;
        in_sof   = s;
        in_eol   = e;
        in_data  = d;
        tick();
    endtask

    task automatic bubble();
        logic [CH*DW-1:0] d;
        rand_data(d);
        send(1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic ch0_px(input logic s, input logic e, input logic [DW-1:0] x);
        logic [CH*DW-1:0] d;
        rand_data(d);
        d[0 +: DW] = x;
        send(1'b1, s, e, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [CH*DW-1:0] d;

        cfg_update = 1'b0;
        cfg_zero_mask = '0; cfg_pole_mask = '0; cfg_order = '0;
        m_sz = '0; m_sp = '0; m_so = '0; m_az = '0; m_ap = '0; m_ao = '0;
        m_pend = 1'b0; m_err = 1'b0;
        ev_valid = 1'b0; ev_sof = 1'b0; ev_eol = 1'b0;
        ev_dw = '0; ev_ds = '0; ev_raw = '0;

        // Reset held for two cycles while every input toggles randomly
        cur_tag = "reset";
        reset = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            ready = 1'($urandom); in_valid = 1'($urandom);
            in_sof = 1'($urandom); in_eol = 1'($urandom);
            rand_data(in_data);
            cfg_zero_mask = CH'($urandom); cfg_pole_mask = CH'($urandom);
            cfg_order = (CH*OW)'($urandom); cfg_update = 1'($urandom);
            tick();
        end
        reset = 1'b0;
        ready = 1'b1;

        // With no configuration loaded, a pixel sums to 0
        cur_tag = "nocfg";
        rand_data(d);
        send(1'b1, 1'b1, 1'b1, d);
        repeat (LAT) bubble();

        // Basic: ch0,ch1 zeros; ch2 pole; order 1 everywhere
        cur_tag = "basic";
        load_cfg(8'h03, 8'h04, 16'h5555);
        bubble();
        d = {CH{16'd7}};
        d[0 +: DW]  = 16'd100;
        d[16 +: DW] = 16'd200;
        d[32 +: DW] = 16'd50;
        send(1'b1, 1'b1, 1'b0, d);
        repeat (LAT - 1) bubble();
        chk("basic.exact_valid", w_valid, 1);
        chk("basic.exact_sof",   w_sof,   1);
        chk("basic.exact_data",  w_data,  16'd250);
        chk("basic.exact_raw",   w_raw,   22'd250);
        bubble();

        // Order 3 zero, x=0x3000: raw 36864, wraps to 0x9000, clamps to 0x7FFF
        cur_tag = "order_zero";
        load_cfg(8'h01, 8'h00, 16'h0003);
        bubble();
        ch0_px(1'b1, 1'b1, 16'h3000);
        repeat (LAT - 1) bubble();
        chk("order_zero.raw",   w_raw,  22'd36864);
        chk("order_zero.wrap",  w_data, 16'h9000);
        chk("order_zero.clamp", s_data, 16'h7FFF);

        // Order 3 pole: raw -36864, wraps to 0x7000, clamps to 0x8000
        cur_tag = "order_pole";
        load_cfg(8'h00, 8'h01, 16'h0003);
        bubble();
        ch0_px(1'b1, 1'b1, 16'h3000);
        repeat (LAT - 1) bubble();
        chk("order_pole.raw",   w_raw,  22'h3F7000);
        chk("order_pole.wrap",  w_data, 16'h7000);
        chk("order_pole.clamp", s_data, 16'h8000);

        // Frame-aligned update: a sign flip takes effect only at the next SOF
        cur_tag = "frame";
        load_cfg(8'h01, 8'h00, 16'h0001);
        bubble();
        ch0_px(1'b1, 1'b0, 16'd500);
        ch0_px(1'b0, 1'b0, 16'd600);
        load_cfg(8'h00, 8'h01, 16'h0001);
        ch0_px(1'b0, 1'b0, 16'd700);
        chk("frame.pending_set", w_pend, 1);
        ch0_px(1'b0, 1'b1, 16'd800);
        ch0_px(1'b1, 1'b0, 16'd900);
        chk("frame.pending_clr", w_pend, 0);
        repeat (LAT) bubble();

        // The apply and a new cfg_update land on the same SOF
        cur_tag = "simul";
        load_cfg(8'h01, 8'h00, 16'h0001);
        bubble();
        load_cfg(8'h00, 8'h01, 16'h0001);
        ch0_px(1'b1, 1'b1, 16'd300);
        chk("simul.pending_kept", w_pend, 1);
        ch0_px(1'b1, 1'b1, 16'd300);
        repeat (LAT) bubble();

        // Stall mid-stream: outputs freeze, and staging still captures
        cur_tag = "stall";
        load_cfg(8'hF0, 8'h0F, 16'hB4E7);
        bubble();
        for (int n = 0; n < 8; n++) begin
            if (n == 6) begin
                ready = 1'b0;
                load_cfg(8'h0F, 8'hF0, 16'h1234);
                for (int s = 0; s < 3; s++) begin
                    rand_data(d);
                    send(1'b1, 1'(s == 0), 1'b1, d);
                end
                chk("stall.pending", w_pend, 1);
                ready = 1'b1;
            end
            rand_data(d);
            send(1'b1, 1'(n == 0), 1'(n == 7), d);
        end
        repeat (LAT) bubble();

        // Conflicting channel is disabled and flags cfg_error
        cur_tag = "conflict";
        load_cfg(8'h08, 8'h08, 16'h0040);
        bubble();
        rand_data(d);
        d[48 +: DW] = 16'd1000;
        send(1'b1, 1'b1, 1'b1, d);
        chk("conflict.error_set", w_err, 1);
        repeat (LAT - 1) bubble();
        chk("conflict.data", w_data, 16'd0);
        load_cfg(8'h08, 8'h00, 16'h0040);
        bubble();
        chk("conflict.error_held", w_err, 1);
        send(1'b1, 1'b1, 1'b1, d);
        chk("conflict.error_clr", w_err, 0);
        repeat (LAT - 1) bubble();
        chk("conflict.clean_data", w_data, 16'd1000);

        // Random traffic with random stalls and configuration updates
        cur_tag = "random";
        for (int n = 0; n < 120; n++) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0)
                load_cfg(CH'($urandom), CH'($urandom), (CH*OW)'($urandom));
            rand_data(d);
            send(1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom), d);
        end
        ready = 1'b1;

        // Mid-frame reset flushes everything in flight
        cur_tag = "midreset";
        load_cfg(8'hFF, 8'h00, 16'h5555);
        for (int n = 0; n < 3; n++) begin
            rand_data(d);
            send(1'b1, 1'(n == 0), 1'b0, d);
        end
        reset = 1'b1;
        bubble();
        reset = 1'b0;
        repeat (LAT + 1) bubble();

        // Drain whatever the scoreboard still holds (bounded)
        cur_tag = "drain";
        for (int n = 0; n < 50 && sb.size() > 0; n++)
            bubble();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
